// File: rtl/scaler_h_ctrl_if.sv
// scaler_h_ctrl_if
//   Signal bundle between the video source / host and scaler_h_ctrl, and from
//   scaler_h_ctrl toward scaler_h.
//   Parameters: PIXEL_WIDTH (pixel data), STEP_WIDTH (scale step),
//               CNT_WIDTH (pixel/line counters).
//   Modports:
//     master - host and source side: drives cfg_step_i, cfg_wr_i, di_i, de_i,
//              hs_i, vs_i; observes every controller output.
//     slave  - the controller itself.
interface scaler_h_ctrl_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int STEP_WIDTH  = 16,
  parameter int CNT_WIDTH   = 12
) ();
  logic [STEP_WIDTH-1:0]  cfg_step_i;
  logic                   cfg_wr_i;
  logic                   cfg_pend_o;
  logic                   cfg_rej_o;
  logic [STEP_WIDTH-1:0]  scale_step_o;
  logic [PIXEL_WIDTH-1:0] di_i;
  logic                   de_i;
  logic                   hs_i;
  logic                   vs_i;
  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;
  logic [1:0]             err_o;
  logic [CNT_WIDTH-1:0]   line_width_o;
  logic [CNT_WIDTH-1:0]   frame_height_o;
  logic                   stat_vld_o;

  modport master (
    output cfg_step_i, cfg_wr_i, di_i, de_i, hs_i, vs_i,
    input  cfg_pend_o, cfg_rej_o, scale_step_o, do_o, de_o, hs_o, vs_o,
           err_o, line_width_o, frame_height_o, stat_vld_o
  );

  modport slave (
    input  cfg_step_i, cfg_wr_i, di_i, de_i, hs_i, vs_i,
    output cfg_pend_o, cfg_rej_o, scale_step_o, do_o, de_o, hs_o, vs_o,
           err_o, line_width_o, frame_height_o, stat_vld_o
  );
endinterface

// File: rtl/scaler_h_ctrl.sv
// scaler_h_ctrl
//   Frame-synchronous front end for scaler_h. Converts level-style source sync
//   (vs_i high = frame active, hs_i high = blanking) into a one-cycle line-start
//   pulse (hs_o) and an active-low frame signal (vs_o), delays pixel data by one
//   cycle, and holds host step writes until the next frame start so that
//   scale_step_o is constant for a whole frame.
//   Ports:
//     clk, rst  - single clock, synchronous active-high reset
//     bus       - scaler_h_ctrl_if.slave: cfg_step_i/cfg_wr_i (host write),
//                 cfg_pend_o/cfg_rej_o (write status), scale_step_o,
//                 di_i/de_i/hs_i/vs_i (source), do_o/de_o/hs_o/vs_o (to scaler),
//                 err_o (sticky), line_width_o/frame_height_o/stat_vld_o.
//   Build option:
//     SCALER_H_CTRL_STAT_EN - builds the pixel/line counters, the geometry
//     report and err_o[1]. Left undefined, those outputs are tied to 0.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   SYNC    | after reset; waits for vs_i low, discarding any partial frame
//   VBLANK  | vertical blank; vs_i rise applies the pending step
//   HBLANK  | horizontal blank inside an active frame
//   LINE    | active part of a line; pixels are forwarded and counted
module scaler_h_ctrl #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int STEP_WIDTH   = 16,
  parameter int STEP_DEFAULT = 128,
  parameter int CNT_WIDTH    = 12
) (
  input  logic           clk,
  input  logic           rst,
  scaler_h_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_HBLANK = 2'd2,
    ST_LINE   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   apply, line_start, line_end, frame_end;

  logic [STEP_WIDTH-1:0]  step_q, pend_val;
  logic                   pend_q, rej_q;
  logic                   cfg_ok;
  logic [PIXEL_WIDTH-1:0] do_q;
  logic                   de_q, hs_q, vs_q, hs_d;
  logic                   err_blank, err_geom;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    apply      = 1'b0;
    line_start = 1'b0;
    line_end   = 1'b0;
    frame_end  = 1'b0;
    case (state)
      ST_SYNC: begin
        if (!bus.vs_i) state_nxt = ST_VBLANK;
      end
      ST_VBLANK: begin
        if (bus.vs_i) begin
          state_nxt = ST_HBLANK;
          apply     = 1'b1;
        end
      end
      ST_HBLANK: begin
        // a frame may also end while still in horizontal blank
        if (!bus.vs_i) begin
          state_nxt = ST_VBLANK;
          frame_end = 1'b1;
        end else if (!bus.hs_i) begin
          state_nxt  = ST_LINE;
          line_start = 1'b1;
        end
      end
      ST_LINE: begin
        if (bus.hs_i) begin
          line_end = 1'b1;
          if (bus.vs_i) begin
            state_nxt = ST_HBLANK;
          end else begin
            state_nxt = ST_VBLANK;
            frame_end = 1'b1;
          end
        end
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  // Step scheduling. A write landing in the apply cycle does not disturb the
  // apply: the old pending value goes live and the new one stays pending.
  assign cfg_ok = bus.cfg_wr_i && (bus.cfg_step_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= STEP_WIDTH'(STEP_DEFAULT);
      pend_val <= STEP_WIDTH'(STEP_DEFAULT);
      pend_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      rej_q <= bus.cfg_wr_i && (bus.cfg_step_i == '0);
      if (apply && pend_q) step_q <= pend_val;
      if (cfg_ok) begin
        pend_val <= bus.cfg_step_i;
        pend_q   <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Video path. The HBLANK cycle that launches a line already carries the
  // first pixel, so it is neither masked from de_o nor flagged as an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_q      <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b1;
      hs_d      <= 1'b1;
      err_blank <= 1'b0;
    end else begin
      do_q <= bus.di_i;
      de_q <= bus.de_i && ((state == ST_LINE) || (state_nxt == ST_LINE));
      hs_q <= (state != ST_SYNC) && hs_d && !bus.hs_i;
      vs_q <= (state == ST_SYNC) ? 1'b1 : !bus.vs_i;
      hs_d <= bus.hs_i;
      if (((state == ST_HBLANK) || (state == ST_VBLANK)) && bus.de_i &&
          (state_nxt != ST_LINE))
        err_blank <= 1'b1;
    end
  end

`ifdef SCALER_H_CTRL_STAT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] pix_cnt, line_cnt, first_w, last_w;
  logic [CNT_WIDTH-1:0] line_pix, line_tot;
  logic [CNT_WIDTH-1:0] width_q, height_q;
  logic                 stat_vld_q;

  // counts including the current cycle, both saturating
  assign line_pix = (bus.de_i && (pix_cnt != CNT_MAX)) ? pix_cnt + CNT_WIDTH'(1) : pix_cnt;
  assign line_tot = (line_cnt != CNT_MAX) ? line_cnt + CNT_WIDTH'(1) : line_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      first_w    <= '0;
      last_w     <= '0;
      width_q    <= '0;
      height_q   <= '0;
      stat_vld_q <= 1'b0;
      err_geom   <= 1'b0;
    end else begin
      stat_vld_q <= frame_end;
      if (apply) line_cnt <= '0;
      if (line_start)            pix_cnt <= CNT_WIDTH'(bus.de_i);
      else if (state == ST_LINE) pix_cnt <= line_pix;
      if (line_end) begin
        line_cnt <= line_tot;
        last_w   <= line_pix;
        if (line_cnt == '0)          first_w  <= line_pix;
        else if (line_pix != first_w) err_geom <= 1'b1;
      end
      if (frame_end) begin
        if (line_end) begin
          width_q  <= line_pix;
          height_q <= line_tot;
        end else begin
          width_q  <= last_w;
          height_q <= line_cnt;
        end
      end
    end
  end

  assign bus.line_width_o   = width_q;
  assign bus.frame_height_o = height_q;
  assign bus.stat_vld_o     = stat_vld_q;
`else
  logic unused_stat;
  assign unused_stat        = ^{line_start, line_end, frame_end};
  assign err_geom           = 1'b0;
  assign bus.line_width_o   = {CNT_WIDTH{1'b0}};
  assign bus.frame_height_o = {CNT_WIDTH{1'b0}};
  assign bus.stat_vld_o     = 1'b0;
`endif

  assign bus.scale_step_o = step_q;
  assign bus.cfg_pend_o   = pend_q;
  assign bus.cfg_rej_o    = rej_q;
  assign bus.do_o         = do_q;
  assign bus.de_o         = de_q;
  assign bus.hs_o         = hs_q;
  assign bus.vs_o         = vs_q;
  assign bus.err_o        = {err_geom, err_blank};

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Bench for scaler_h_ctrl: frame generator with a behavioural model that
// pushes expected pixels, reports and reject pulses into queues; a negedge
// monitor pops and compares them and checks per-cycle status against the model.
module tb_scaler_h_ctrl;
  localparam int HB = 4;
  localparam int VB = 6;
`ifdef SCALER_H_CTRL_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  typedef struct { logic [7:0] d; logic first; } pix_t;
  typedef struct { int w; int h; } stat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scaler_h_ctrl_if #(.PIXEL_WIDTH(8), .STEP_WIDTH(16), .CNT_WIDTH(12)) bus ();

  scaler_h_ctrl #(
    .PIXEL_WIDTH(8), .STEP_WIDTH(16), .STEP_DEFAULT(128), .CNT_WIDTH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;

  pix_t  pix_q[$];
  stat_t stat_q[$];
  int    n_rej_exp = 0;

  // model state visible to the monitor (values after the last clock edge)
  logic [15:0] m_step = 16'd128;
  logic        m_pend = 1'b0;
  logic [1:0]  m_err  = 2'b00;
  // model-internal
  logic [15:0] m_pv = 16'd128;
  logic        m_synced = 1'b0, m_live = 1'b0, m_hs_q = 1'b1;
  int          m_pix = 0, m_lines = 0, m_first = 0, m_last = 0;

  int opt_wr_line[2], opt_wr_val[2];
  int opt_apply_wr, opt_short, opt_glitch, opt_rst_line;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Evaluate the model on the inputs about to be sampled, then clock.
  task automatic cyc();
    logic [15:0] n_step = m_step;
    logic [15:0] n_pv   = m_pv;
    logic        n_pend = m_pend;
    logic [1:0]  n_err  = m_err;
    pix_t        p;
    stat_t       s;
    if (rst) begin
      n_step = 16'd128; n_pv = 16'd128; n_pend = 1'b0; n_err = 2'b00;
      m_synced = 1'b0; m_live = 1'b0; m_pix = 0; m_lines = 0;
    end else begin
      if (bus.cfg_wr_i && bus.cfg_step_i == 16'd0) n_rej_exp++;
      if (m_synced && !m_live && bus.vs_i) begin
        if (m_pend) n_step = m_pv;
        n_pend  = 1'b0;
        m_live  = 1'b1;
        m_lines = 0;
        m_pix   = 0;
      end
      if (bus.cfg_wr_i && bus.cfg_step_i != 16'd0) begin
        n_pv   = bus.cfg_step_i;
        n_pend = 1'b1;
      end
      if (bus.de_i && bus.hs_i && m_synced) n_err[0] = 1'b1;
      if (m_live && bus.vs_i && !bus.hs_i && bus.de_i) begin
        p.d = bus.di_i; p.first = m_hs_q;
        pix_q.push_back(p);
        m_pix++;
      end
      if (m_live && bus.hs_i && !m_hs_q) begin
        if (m_lines == 0) m_first = m_pix;
        else if (STAT && m_pix != m_first) n_err[1] = 1'b1;
        m_lines++;
        m_last = m_pix;
        m_pix  = 0;
      end
      if (m_live && !bus.vs_i) begin
        if (STAT) begin s.w = m_last; s.h = m_lines; stat_q.push_back(s); end
        m_live = 1'b0;
      end
      if (!bus.vs_i) m_synced = 1'b1;
    end
    m_hs_q = bus.hs_i;
    @(posedge clk);
    #1;
    m_step = n_step; m_pv = n_pv; m_pend = n_pend; m_err = n_err;
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs);
    bus.de_i = de; bus.hs_i = hs; bus.vs_i = vs;
    bus.di_i = 8'($urandom);
    cyc();
    bus.cfg_wr_i = 1'b0;
  endtask

  task automatic clear_opts();
    opt_wr_line[0] = -1; opt_wr_line[1] = -1;
    opt_wr_val[0] = 0;   opt_wr_val[1] = 0;
    opt_apply_wr = -1; opt_short = -1; opt_glitch = -1; opt_rst_line = -1;
  endtask

  task automatic run_frame(input int w, input int h);
    if (opt_apply_wr >= 0) begin
      bus.cfg_wr_i = 1'b1; bus.cfg_step_i = 16'(opt_apply_wr);
    end
    drive(1'b0, 1'b1, 1'b1);
    for (int l = 0; l < h; l++) begin
      int wl;
      wl = (l == opt_short) ? w - 1 : w;
      for (int k = 0; k < HB; k++) drive((l == opt_glitch) && (k == 2), 1'b1, 1'b1);
      for (int x = 0; x < wl; x++) begin
        if (l == opt_rst_line && x == 3) rst = 1'b1;
        if (l == opt_rst_line && x == 5) rst = 1'b0;
        for (int s = 0; s < 2; s++)
          if (l == opt_wr_line[s] && x == 2 + 2 * s) begin
            bus.cfg_wr_i = 1'b1; bus.cfg_step_i = 16'(opt_wr_val[s]);
          end
        drive(1'b1, 1'b0, 1'b1);
      end
      drive(1'b0, 1'b1, (l == h - 1) ? 1'b0 : 1'b1);
    end
    for (int k = 0; k < VB; k++) drive(1'b0, 1'b1, 1'b0);
  endtask

  // monitor
  logic p_rst = 1'b1, p_vs = 1'b1, p_sync = 1'b0;
  int   held_w = 0, held_h = 0;
  always @(negedge clk) begin
    pix_t  pe;
    stat_t se;
    if (p_rst) begin
      chk("rst do_o", 32'(bus.do_o), 32'd0);
      chk("rst de_o", 32'(bus.de_o), 32'd0);
      chk("rst hs_o", 32'(bus.hs_o), 32'd0);
      chk("rst vs_o", 32'(bus.vs_o), 32'd1);
      chk("rst stat_vld_o", 32'(bus.stat_vld_o), 32'd0);
      chk("rst cfg_rej_o", 32'(bus.cfg_rej_o), 32'd0);
      held_w = 0; held_h = 0;
    end else begin
      chk("vs_o", 32'(bus.vs_o), p_sync ? 32'(!p_vs) : 32'd1);
      if (bus.de_o) begin
        chk("pixel expected", 32'(pix_q.size() != 0), 32'd1);
        if (pix_q.size() != 0) begin
          pe = pix_q.pop_front();
          chk("do_o", 32'(bus.do_o), 32'(pe.d));
          chk("hs_o at pixel", 32'(bus.hs_o), 32'(pe.first));
        end
      end else begin
        chk("hs_o without de_o", 32'(bus.hs_o), 32'd0);
      end
      if (bus.cfg_rej_o) begin
        chk("cfg_rej_o expected", 32'(n_rej_exp > 0), 32'd1);
        if (n_rej_exp > 0) n_rej_exp--;
      end
`ifdef SCALER_H_CTRL_STAT_EN
      if (bus.stat_vld_o) begin
        chk("stat expected", 32'(stat_q.size() != 0), 32'd1);
        if (stat_q.size() != 0) begin
          se = stat_q.pop_front();
          held_w = se.w; held_h = se.h;
        end
      end
`else
      chk("stat_vld_o tied", 32'(bus.stat_vld_o), 32'd0);
`endif
    end
    chk("line_width_o", 32'(bus.line_width_o), 32'(held_w));
    chk("frame_height_o", 32'(bus.frame_height_o), 32'(held_h));
    chk("scale_step_o", 32'(bus.scale_step_o), 32'(m_step));
    chk("cfg_pend_o", 32'(bus.cfg_pend_o), 32'(m_pend));
    chk("err_o", 32'(bus.err_o), 32'(m_err));
    p_sync = p_rst ? 1'b0 : (p_sync | !p_vs);
    p_rst  = rst;
    p_vs   = bus.vs_i;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int w, h;
    bus.cfg_step_i = 16'd0; bus.cfg_wr_i = 1'b0;
    bus.di_i = 8'd0; bus.de_i = 1'b0; bus.hs_i = 1'b1; bus.vs_i = 1'b1;
    clear_opts();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < VB; i++) drive(1'b0, 1'b1, 1'b0);

    // plain 24x24 frame
    run_frame(24, 24);
    // step 256 written mid-frame, applied at the next frame
    opt_wr_line[0] = 3; opt_wr_val[0] = 256;
    run_frame(24, 24);
    clear_opts();
    run_frame(12, 8);
    // 300 then 384 in one frame; 512 in the apply cycle
    opt_wr_line[0] = 1; opt_wr_val[0] = 300;
    opt_wr_line[1] = 2; opt_wr_val[1] = 384;
    run_frame(10, 6);
    clear_opts();
    opt_apply_wr = 512;
    run_frame(10, 6);
    // rejected zero write while 512 is pending
    clear_opts();
    opt_wr_line[0] = 1; opt_wr_val[0] = 0;
    run_frame(10, 6);
    clear_opts();
    run_frame(10, 6);
    // de in hblank, short line 5
    opt_glitch = 2; opt_short = 5;
    run_frame(16, 8);
    // random frames
    for (int f = 0; f < 4; f++) begin
      clear_opts();
      w = int'($urandom_range(8, 20));
      h = int'($urandom_range(6, 12));
      opt_wr_line[0] = int'($urandom_range(0, h - 1));
      opt_wr_val[0]  = 128 * int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        opt_wr_line[1] = int'($urandom_range(0, h - 1));
        opt_wr_val[1]  = 128 * int'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 1) opt_apply_wr = 64 * int'($urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) opt_short = int'($urandom_range(1, h - 1));
      run_frame(w, h);
    end
    // reset in the middle of a line, then a full frame
    clear_opts();
    opt_rst_line = 3;
    run_frame(20, 10);
    clear_opts();
    run_frame(14, 9);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);

    chk("pixels drained", 32'(pix_q.size()), 32'd0);
    chk("reports drained", 32'(stat_q.size()), 32'd0);
    chk("rejects drained", 32'(n_rej_exp), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
